// File: rtl/threshold_sequencer.sv
// threshold_sequencer: stages per-channel HSV threshold masks in shadow
// registers, commits them to the live outputs on a frame boundary, and flags
// a settling window while the colour-reduction pipeline flushes.
module threshold_sequencer #(
  parameter int PIPE_LATENCY = 8,
  parameter int DEF_H_BITS   = 3,
  parameter int DEF_S_BITS   = 2,
  parameter int DEF_V_BITS   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       select,
  input  logic [1:0] selector,
  input  logic [2:0] inputVal,
  input  logic       frame_start,
  output logic [7:0] hThreshold,
  output logic [7:0] sThreshold,
  output logic [7:0] vThreshold,
  output logic       pending,
  output logic       settling
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  // Mask with depth+1 leading ones.
  function automatic logic [7:0] mask_of(input logic [2:0] depth);
    return 8'hFF << (3'd7 - depth);
  endfunction

  localparam logic [7:0] DEF_H   = mask_of(3'(DEF_H_BITS - 1));
  localparam logic [7:0] DEF_S   = mask_of(3'(DEF_S_BITS - 1));
  localparam logic [7:0] DEF_V   = mask_of(3'(DEF_V_BITS - 1));
  localparam logic [7:0] LAT     = 8'(PIPE_LATENCY);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       edit_flag_q, edit_flag_d;
  logic [7:0] shadow_h_q, shadow_h_d;
  logic [7:0] shadow_s_q, shadow_s_d;
  logic [7:0] shadow_v_q, shadow_v_d;
  logic [7:0] live_h_q, live_h_d;
  logic [7:0] live_s_q, live_s_d;
  logic [7:0] live_v_q, live_v_d;
  logic [7:0] edit_mask;

  assign edit_mask = mask_of(inputVal);

  // Shadow edits apply in every state; the same-cycle edit is visible to a
  // commit so a merged edit lands directly in the live masks.
  always_comb begin
    shadow_h_d  = shadow_h_q;
    shadow_s_d  = shadow_s_q;
    shadow_v_d  = shadow_v_q;
    if (select) begin
      case (selector)
        2'd0: shadow_h_d = edit_mask;
        2'd1: shadow_s_d = edit_mask;
        2'd2: shadow_v_d = edit_mask;
        default: begin
          shadow_h_d = DEF_H;
          shadow_s_d = DEF_S;
          shadow_v_d = DEF_V;
        end
      endcase
    end
  end

  // Commit/settle sequencing and edit bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edit_flag_d = edit_flag_q | select;
    live_h_d    = live_h_q;
    live_s_d    = live_s_q;
    live_v_d    = live_v_q;
    case (state_q)
      IDLE: begin
        // A frame boundary with nothing staged is a no-op.
        if (select) state_d = PENDING;
      end
      PENDING: begin
        if (frame_start) begin
          live_h_d    = shadow_h_d;
          live_s_d    = shadow_s_d;
          live_v_d    = shadow_v_d;
          edit_flag_d = 1'b0;
          cnt_d       = LAT;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        // Frame boundaries are ignored here; staged edits wait for the
        // next frame_start after the window closes.
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = edit_flag_d ? PENDING : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, shadow and live registers; reset restores defaults.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      edit_flag_q <= 1'b0;
      shadow_h_q  <= DEF_H;
      shadow_s_q  <= DEF_S;
      shadow_v_q  <= DEF_V;
      live_h_q    <= DEF_H;
      live_s_q    <= DEF_S;
      live_v_q    <= DEF_V;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edit_flag_q <= edit_flag_d;
      shadow_h_q  <= shadow_h_d;
      shadow_s_q  <= shadow_s_d;
      shadow_v_q  <= shadow_v_d;
      live_h_q    <= live_h_d;
      live_s_q    <= live_s_d;
      live_v_q    <= live_v_d;
    end
  end

  assign hThreshold = live_h_q;
  assign sThreshold = live_s_q;
  assign vThreshold = live_v_q;
  assign pending    = edit_flag_q;
  assign settling   = (state_q == SETTLE);

endmodule

// File: tb/tb_threshold_sequencer.sv
// Bench for threshold_sequencer: directed scenarios with literal expectations
// followed by random stimulus, all cross-checked every cycle against a
// behavioural model.
module tb_threshold_sequencer;

  localparam int LAT = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       select = 1'b0;
  logic [1:0] selector = 2'd0;
  logic [2:0] inputVal = 3'd0;
  logic       frame_start = 1'b0;
  logic [7:0] hThreshold, sThreshold, vThreshold;
  logic       pending, settling;

  int errors = 0;
  int checks = 0;

  threshold_sequencer #(
    .PIPE_LATENCY(LAT), .DEF_H_BITS(3), .DEF_S_BITS(2), .DEF_V_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .select(select), .selector(selector),
    .inputVal(inputVal), .frame_start(frame_start),
    .hThreshold(hThreshold), .sThreshold(sThreshold), .vThreshold(vThreshold),
    .pending(pending), .settling(settling)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A mask of n ones counted from the MSB.
  function automatic logic [7:0] ones_from_top(input int n);
    logic [7:0] m = 8'h00;
    for (int i = 0; i < n; i++) m[7-i] = 1'b1;
    return m;
  endfunction

  logic [7:0] m_sh[3];
  logic [7:0] m_live[3];
  bit         m_staged;
  int         m_left;   // cycles of settling still to show
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    bit commit;
    if (reset) begin
      m_sh[0] = 8'hE0; m_sh[1] = 8'hC0; m_sh[2] = 8'hC0;
      m_live = m_sh;
      m_staged = 1'b0;
      m_left = 0;
    end else begin
      commit = frame_start && m_staged && (m_left == 0);
      if (select) begin
        if (selector == 2'd3) begin
          m_sh[0] = 8'hE0; m_sh[1] = 8'hC0; m_sh[2] = 8'hC0;
        end else begin
          m_sh[selector] = ones_from_top(int'(inputVal) + 1);
        end
      end
      if (commit) begin
        m_live = m_sh;
        m_staged = 1'b0;
        m_left = LAT;
      end else begin
        if (m_left > 0) m_left--;
        if (select) m_staged = 1'b1;
      end
    end
    m_valid = 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_h", hThreshold, m_live[0]);
      check("model_s", sThreshold, m_live[1]);
      check("model_v", vThreshold, m_live[2]);
      check("model_pending", {7'd0, pending}, {7'd0, m_staged});
      check("model_settling", {7'd0, settling}, {7'd0, m_left > 0});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit s, input logic [1:0] sr, input logic [2:0] v,
                     input bit fs, input bit rst);
    select = s; selector = sr; inputVal = v; frame_start = fs; reset = rst;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_settle();
    int n = 0;
    while (settling && n < 300) begin
      idle();
      n++;
    end
    check("settle_timeout", {7'd0, settling}, 8'd0);
  endtask

  initial begin
    int n;
    // Reset
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("rst_h", hThreshold, 8'hE0);
    check("rst_s", sThreshold, 8'hC0);
    check("rst_v", vThreshold, 8'hC0);
    check("rst_pending", {7'd0, pending}, 8'd0);
    check("rst_settling", {7'd0, settling}, 8'd0);
    idle();
    // Frame boundary with nothing staged does nothing
    cyc(0, 0, 0, 1, 0);
    check("idle_fs_settling", {7'd0, settling}, 8'd0);

    // Staged edit then commit
    cyc(1, 1, 4, 0, 0);
    check("staged_s", sThreshold, 8'hC0);
    check("staged_pending", {7'd0, pending}, 8'd1);
    cyc(0, 0, 0, 1, 0);
    check("commit_s", sThreshold, 8'hF8);
    check("commit_pending", {7'd0, pending}, 8'd0);
    n = 0;
    while (settling && n < 20) begin
      n++;
      idle();
    end
    check("settle_len", 8'(n), 8'(LAT));

    // Deferred commit
    cyc(1, 1, 4, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("defer_h", hThreshold, 8'hE0);
    check("defer_settling", {7'd0, settling}, 8'd1);
    wait_settle();
    check("defer_pending", {7'd0, pending}, 8'd1);
    check("defer_h_after", hThreshold, 8'hE0);
    cyc(0, 0, 0, 1, 0);
    check("defer_commit_h", hThreshold, 8'h80);
    wait_settle();

    // Merged edit in PENDING
    cyc(1, 1, 1, 0, 0);
    cyc(1, 2, 7, 1, 0);
    check("merge_v", vThreshold, 8'hFF);
    check("merge_s", sThreshold, 8'hC0);
    check("merge_pending", {7'd0, pending}, 8'd0);
    wait_settle();

    // Restore defaults
    cyc(1, 0, 7, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("pre_restore_h", hThreshold, 8'hFF);
    wait_settle();
    cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("restore_h", hThreshold, 8'hE0);
    check("restore_s", sThreshold, 8'hC0);
    check("restore_v", vThreshold, 8'hC0);
    wait_settle();

    // Reset mid-SETTLE
    cyc(1, 0, 7, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("midrst_pre_h", hThreshold, 8'hFF);
    idle();
    idle();
    cyc(0, 0, 0, 0, 1);
    check("midrst_h", hThreshold, 8'hE0);
    check("midrst_settling", {7'd0, settling}, 8'd0);
    check("midrst_pending", {7'd0, pending}, 8'd0);
    idle();

    // Random phase
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
          3'($urandom_range(0, 7)), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 299) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
